// File: rtl/alu_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : alu_sequencer
// Description : Multi-cycle fetch/decode/execute/writeback controller for the
//               32-bit ALU datapath. Owns the program counter and the two-bit
//               flag register; writes ALU results back to the register file.
//               Optional macro ALU_SEQ_PERF_EN adds retired/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ALU_WAIT = 1,
    parameter logic [6:0]  HALT_OP  = 7'h7F
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [3:0]  rf_ra,
    output logic [3:0]  rf_rb,
    output logic        rf_we,
    output logic [3:0]  rf_wa,
    output logic [31:0] rf_wdata,
    output logic [6:0]  alu_instr,
    output logic [15:0] alu_value,
    output logic        alu_highlow,
    output logic        alu_F1,
    output logic        alu_F2,
    input  logic        alu_F3,
    input  logic [31:0] alu_C,
    input  logic        alu_addrch,
    input  logic [31:0] alu_naddr,
    output logic [31:0] pc,
    output logic        busy,
    output logic        halted,
`ifdef ALU_SEQ_PERF_EN
    output logic [31:0] retired,
    output logic [31:0] stall_cycles,
`endif
    output logic        illegal
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_DECODE = 3'd2;
    localparam logic [2:0] c_ST_EXEC   = 3'd3;
    localparam logic [2:0] c_ST_WB     = 3'd4;
    localparam logic [2:0] c_ST_HALT   = 3'd5;

    // EXEC lasts ALU_WAIT cycles: count down from ALU_WAIT-1 to zero
    localparam logic [3:0] c_WAIT_LAST = 4'(ALU_WAIT - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [31:0] r_pc;
    logic [1:0]  r_flags;
    logic        r_illegal;
    logic [31:0] r_instr;
    logic [3:0]  r_wait;
    logic [31:0] r_c;
    logic        r_f3;
    logic        r_addrch;
    logic [31:0] r_naddr;

    logic [6:0]  w_op;
    logic        w_hl;
    logic [3:0]  w_rd;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [15:0] w_imm;
    logic        w_illegal_op;
    logic        w_halt_op;
    logic        w_alu_drive;
    logic        w_exec_last;
    logic        w_wb_write;
    logic        w_wb_flag;
    logic        w_wb_jump;

    assign w_op  = r_instr[6:0];
    assign w_hl  = r_instr[7];
    assign w_rd  = r_instr[11:8];
    assign w_ra  = r_instr[15:12];
    assign w_rb  = r_instr[19:16];
    assign w_imm = r_instr[31:16];

    // Opcodes 16..126 are reserved; the halt opcode takes priority over them
    assign w_halt_op    = (w_op == HALT_OP);
    assign w_illegal_op = (w_op >= 7'd16) && (w_op <= 7'd126) && !w_halt_op;

    assign w_alu_drive = (r_state == c_ST_DECODE) || (r_state == c_ST_EXEC);
    assign w_exec_last = (r_state == c_ST_EXEC) && (r_wait == 4'd0);
    assign w_wb_write  = (r_state == c_ST_WB) && (w_op <= 7'd7);
    assign w_wb_flag   = (w_op >= 7'd8) && (w_op <= 7'd13);
    assign w_wb_jump   = (w_op == 7'd14) || (w_op == 7'd15);

    // Next-state selection for the sequencing FSM
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:   if (start) w_next_state = c_ST_FETCH;
            c_ST_FETCH:  if (imem_ack) w_next_state = c_ST_DECODE;
            c_ST_DECODE: begin
                if (w_halt_op || w_illegal_op) w_next_state = c_ST_HALT;
                else                           w_next_state = c_ST_EXEC;
            end
            c_ST_EXEC:   if (r_wait == 4'd0) w_next_state = c_ST_WB;
            c_ST_WB:     w_next_state = c_ST_FETCH;
            c_ST_HALT:   w_next_state = c_ST_HALT;
            default:     w_next_state = c_ST_IDLE;
        endcase
    end

    // State register plus instruction latch, EXEC countdown and ALU sampling
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= c_ST_IDLE;
            r_instr  <= 32'd0;
            r_wait   <= 4'd0;
            r_c      <= 32'd0;
            r_f3     <= 1'b0;
            r_addrch <= 1'b0;
            r_naddr  <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == c_ST_FETCH) && imem_ack) r_instr <= imem_rdata;
            if (r_state == c_ST_DECODE) r_wait <= c_WAIT_LAST;
            else if ((r_state == c_ST_EXEC) && (r_wait != 4'd0)) r_wait <= r_wait - 4'd1;
            if (w_exec_last) begin
                r_c      <= alu_C;
                r_f3     <= alu_F3;
                r_addrch <= alu_addrch;
                r_naddr  <= alu_naddr;
            end
        end
    end

    // Architectural state: PC, flag shift register and sticky illegal bit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc      <= RESET_PC;
            r_flags   <= 2'b00;
            r_illegal <= 1'b0;
        end else begin
            if ((r_state == c_ST_DECODE) && w_illegal_op) r_illegal <= 1'b1;
            if (r_state == c_ST_WB) begin
                if (w_wb_flag) r_flags <= {r_flags[0], r_f3};
                if (w_wb_jump && r_addrch) r_pc <= r_naddr;
                else                       r_pc <= r_pc + 32'd1;
            end
        end
    end

`ifdef ALU_SEQ_PERF_EN
    logic [31:0] r_retired;
    logic [31:0] r_stall;

    // Retirement and fetch-stall counters, free-running with wrap
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_retired <= 32'd0;
            r_stall   <= 32'd0;
        end else begin
            if (r_state == c_ST_WB) r_retired <= r_retired + 32'd1;
            if ((r_state == c_ST_FETCH) && !imem_ack) r_stall <= r_stall + 32'd1;
        end
    end

    assign retired      = r_retired;
    assign stall_cycles = r_stall;
`endif

    // Outputs are forced to zero outside the states that own them
    assign imem_req    = (r_state == c_ST_FETCH);
    assign imem_addr   = imem_req ? r_pc : 32'd0;
    assign rf_ra       = w_alu_drive ? w_ra : 4'd0;
    assign rf_rb       = w_alu_drive ? w_rb : 4'd0;
    assign alu_instr   = w_alu_drive ? w_op : 7'd0;
    assign alu_highlow = w_alu_drive ? w_hl : 1'b0;
    assign alu_value   = (w_alu_drive && ((w_op == 7'd5) || (w_op == 7'd6))) ? w_imm : 16'd0;
    assign alu_F1      = r_flags[0];
    assign alu_F2      = r_flags[1];
    assign rf_we       = w_wb_write;
    assign rf_wa       = w_wb_write ? w_rd : 4'd0;
    assign rf_wdata    = w_wb_write ? r_c : 32'd0;
    assign pc          = r_pc;
    assign busy        = (r_state != c_ST_IDLE) && (r_state != c_ST_HALT);
    assign halted      = (r_state == c_ST_HALT);
    assign illegal     = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Scoreboard bench for alu_sequencer. A reference model predicts
//               fetch addresses, flags and register writes per instruction; a
//               monitor compares them against the DUT. Honours ALU_SEQ_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          ALU_WAIT = 1;
    localparam logic [6:0]  HALT_OP  = 7'h7F;

    logic        clock = 1'b0;
    logic        reset_n, start, imem_req, imem_ack, rf_we, alu_highlow;
    logic        alu_F1, alu_F2, alu_F3, alu_addrch, busy, halted, illegal;
    logic [31:0] imem_addr, imem_rdata, rf_wdata, alu_C, alu_naddr, pc;
    logic [3:0]  rf_ra, rf_rb, rf_wa;
    logic [6:0]  alu_instr;
    logic [15:0] alu_value;
`ifdef ALU_SEQ_PERF_EN
    logic [31:0] retired, stall_cycles;
`endif

    always #5 clock = ~clock;

    alu_sequencer #(.RESET_PC(RESET_PC), .ALU_WAIT(ALU_WAIT), .HALT_OP(HALT_OP)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wdata(rf_wdata),
        .alu_instr(alu_instr), .alu_value(alu_value), .alu_highlow(alu_highlow),
        .alu_F1(alu_F1), .alu_F2(alu_F2), .alu_F3(alu_F3), .alu_C(alu_C),
        .alu_addrch(alu_addrch), .alu_naddr(alu_naddr),
        .pc(pc), .busy(busy), .halted(halted),
`ifdef ALU_SEQ_PERF_EN
        .retired(retired), .stall_cycles(stall_cycles),
`endif
        .illegal(illegal)
    );

    // Behavioural ALU stand-in: every result is a visible function of its inputs
    assign alu_C      = {alu_value, alu_highlow, alu_instr, rf_rb, rf_ra};
    assign alu_F3     = rf_rb[0];
    assign alu_addrch = rf_rb[1];
    assign alu_naddr  = {24'h0, rf_ra, 4'h0};

    typedef struct { logic [31:0] addr; logic [1:0] flags; } fetch_t;
    typedef struct { logic [3:0] wa; logic [31:0] wd; } wr_t;
    fetch_t fq[$];
    wr_t    wq[$];

    int compared = 0;
    int mismatched = 0;
    logic [31:0] m_pc;
    logic [1:0]  m_flags;
    int          m_retired;
    int          m_stalls;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares fetch addresses/flags and register writes with the queues
    int cyc = 0;
    int ack_cyc = 0;
    always @(negedge clock) begin
        #1;
        cyc++;
        if (imem_req) begin
            if (fq.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL unexpected_fetch: got addr %h expected no fetch", imem_addr);
            end else begin
                chk("imem_addr", imem_addr, fq[0].addr);
                if (imem_ack) begin
                    chk("flags_at_fetch", {30'd0, alu_F2, alu_F1}, {30'd0, fq[0].flags});
                    void'(fq.pop_front());
                    ack_cyc = cyc;
                end
            end
        end
        if (rf_we) begin
            if (wq.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL unexpected_write: got wa %h wdata %h expected no write", rf_wa, rf_wdata);
            end else begin
                wr_t w;
                w = wq.pop_front();
                chk("rf_wa", {28'd0, rf_wa}, {28'd0, w.wa});
                chk("rf_wdata", rf_wdata, w.wd);
                chk("wb_latency", 32'(cyc - ack_cyc), 32'(ALU_WAIT + 2));
            end
        end
    end

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [3:0] rd,
                                       input logic [3:0] ra, input logic [3:0] rb);
        logic [31:0] w;
        w = $urandom;
        w[6:0]   = op;
        w[11:8]  = rd;
        w[15:12] = ra;
        w[19:16] = rb;
        return w;
    endfunction

    // Reference model: effect of one instruction on PC, flags and register file
    task automatic model(input logic [31:0] instr);
        logic [6:0]  op;
        logic [15:0] val;
        op = instr[6:0];
        if (op == HALT_OP || (op >= 7'd16 && op <= 7'd126)) return;
        val = (op == 7'd5 || op == 7'd6) ? instr[31:16] : 16'd0;
        if (op <= 7'd7) wq.push_back('{instr[11:8], {val, instr[7], op, instr[19:16], instr[15:12]}});
        if (op >= 7'd8 && op <= 7'd13) m_flags = {m_flags[0], instr[16]};
        if ((op == 7'd14 || op == 7'd15) && instr[17]) m_pc = {24'h0, instr[15:12], 4'h0};
        else m_pc = m_pc + 32'd1;
        m_retired++;
        fq.push_back('{m_pc, m_flags});
    endtask

    task automatic do_reset();
        reset_n = 1'b0; start = 1'b0; imem_ack = 1'b0;
        fq.delete(); wq.delete();
        m_pc = RESET_PC; m_flags = 2'b00; m_retired = 0; m_stalls = 0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic do_start();
        start = 1'b1;
        fq.push_back('{m_pc, m_flags});
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic issue(input logic [31:0] instr, input int delay);
        int n = 0;
        while (!imem_req && n < 50) begin @(negedge clock); n++; end
        if (!imem_req) begin
            compared++; mismatched++;
            $display("FAIL fetch_timeout: got no imem_req expected a fetch within 50 cycles");
            return;
        end
        repeat (delay) @(negedge clock);
        m_stalls += delay;
        imem_rdata = instr;
        imem_ack = 1'b1;
        model(instr);
        @(negedge clock);
        imem_ack = 1'b0;
        imem_rdata = $urandom;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
        m_pc = RESET_PC; m_flags = 2'b00; m_retired = 0; m_stalls = 0;
        repeat (3) @(negedge clock);
        #2;
        chk("reset_pc", pc, RESET_PC);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        chk("reset_illegal", {31'd0, illegal}, 32'd0);
        chk("reset_imem_req", {31'd0, imem_req}, 32'd0);
        chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
        chk("reset_flags", {30'd0, alu_F2, alu_F1}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Directed: add, flag shift, jumps, fetch stall
        do_start();
        issue(mk(7'd0, 4'd3, 4'd1, 4'd2), 0);
        issue(mk(7'd8, 4'd0, 4'd0, 4'd1), 0);
        issue(mk(7'd8, 4'd0, 4'd0, 4'd0), 0);
        issue(mk(7'd12, 4'd0, 4'd0, 4'd0), 0);
        chk("flags_during_op12", {30'd0, alu_F2, alu_F1}, 32'd2);
        issue(mk(7'd15, 4'd0, 4'd4, 4'd2), 0);
        issue(mk(7'd15, 4'd0, 4'd4, 4'd0), 0);
        issue(mk(7'd1, 4'd7, 4'd2, 4'd3), 5);

        // Randomised legal stream, closed by the halt opcode
        for (int i = 0; i < 150; i++) begin
            issue(mk(7'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom)),
                  int'($urandom_range(0, 3)));
        end
        issue(mk(HALT_OP, 4'd0, 4'd0, 4'd0), int'($urandom_range(0, 2)));
        repeat (5) @(negedge clock);
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_illegal", {31'd0, illegal}, 32'd0);
        chk("halt_busy", {31'd0, busy}, 32'd0);
        chk("halt_pc", pc, m_pc);
        chk("fetch_queue_drained", 32'(fq.size()), 32'd0);
        chk("write_queue_drained", 32'(wq.size()), 32'd0);
`ifdef ALU_SEQ_PERF_EN
        chk("retired", retired, 32'(m_retired));
        chk("stall_cycles", stall_cycles, 32'(m_stalls));
`endif

        // Illegal opcode halts, sets sticky flag, ignores start
        do_reset();
        do_start();
        issue(mk(7'h20, 4'd1, 4'd1, 4'd1), 1);
        repeat (4) @(negedge clock);
        chk("illegal_flag", {31'd0, illegal}, 32'd1);
        chk("illegal_halted", {31'd0, halted}, 32'd1);
        chk("illegal_busy", {31'd0, busy}, 32'd0);
        chk("illegal_pc", pc, RESET_PC);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        chk("halt_ignores_start", {31'd0, halted}, 32'd1);
        chk("halt_no_fetch", {31'd0, imem_req}, 32'd0);

        // Asynchronous reset during EXEC
        do_reset();
        do_start();
        issue(mk(7'd0, 4'd5, 4'd1, 4'd1), 0);
        @(negedge clock);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        #2;
        reset_n = 1'b0;
        fq.delete(); wq.delete();
        #1;
        chk("async_reset_pc", pc, RESET_PC);
        chk("async_reset_busy", {31'd0, busy}, 32'd0);
        chk("async_reset_rf_we", {31'd0, rf_we}, 32'd0);
        chk("async_reset_alu_instr", {25'd0, alu_instr}, 32'd0);
        chk("async_reset_rf_ra", {28'd0, rf_ra}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (6) @(negedge clock);
        chk("post_reset_idle", {31'd0, busy}, 32'd0);
        chk("post_reset_pc", pc, RESET_PC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle controller that sequences the 32-bit ALU datapath: fetches instruction words over a req/ack memory port, decodes them, and drives the ALU opcode, immediate and flag inputs and the register-file read addresses. It captures ALU results into the register file or the two-bit flag register, and updates the program counter, including ALU-driven jumps (ops 14/15). It sits between instruction memory, the register file and the ALU, and is the only writer of PC and flags.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ALU_WAIT, 1, EXEC cycles before the ALU outputs are sampled (1..15)
HALT_OP, 7'h7F, opcode that halts cleanly

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; leaves IDLE
imem_req  out  1  fetch request
imem_addr  out  32  fetch word address (= PC)
imem_ack  in  1  fetch data valid
imem_rdata  in  32  instruction word
rf_ra  out  4  register-file read address A (feeds ALU A)
rf_rb  out  4  register-file read address B (feeds ALU B)
rf_we  out  1  register-file write enable
rf_wa  out  4  register-file write address
rf_wdata  out  32  register-file write data
alu_instr  out  7  ALU opcode
alu_value  out  16  ALU immediate
alu_highlow  out  1  ALU load half select
alu_F1  out  1  flag[0]
alu_F2  out  1  flag[1]
alu_F3  in  1  ALU flag result
alu_C  in  32  ALU data result
alu_addrch  in  1  ALU jump-taken
alu_naddr  in  32  ALU jump target
pc  out  32  current PC
busy  out  1  high in every state except IDLE and HALT
halted  out  1  high in HALT
illegal  out  1  sticky; set on an illegal opcode

Behaviour:
- Instruction word fields: [6:0] op, [7] highlow, [11:8] rd, [15:12] ra, [19:16] rb, [31:16] imm16. imm16 and rb overlap; imm16 is used only by ops 5 and 6.
- Reset (asynchronous, any state): state=IDLE, pc=RESET_PC, flags=2'b00, illegal=0. All other outputs are 0. imem_req drops in the reset cycle, mid-fetch included.
- State IDLE: start -> FETCH.
- State FETCH: imem_req=1, imem_addr=pc, both held stable until imem_ack. An ack in the first req cycle is legal. On ack, latch the instruction -> DECODE. An ack seen while req=0 is ignored.
- State DECODE (1 cycle): drive rf_ra=ra, rf_rb=rb.
  - op==HALT_OP -> HALT.
  - op in 16..126 (other than HALT_OP) -> set illegal, go to HALT.
  - Otherwise -> EXEC.
- State EXEC (ALU_WAIT cycles): hold alu_instr, alu_value, alu_highlow, rf_ra, rf_rb and alu_F1/F2 stable. Sample alu_C, alu_F3, alu_addrch and alu_naddr on the last EXEC cycle -> WB.
- State WB (1 cycle), by op:
  - ops 0-7: rf_we=1, rf_wa=rd, rf_wdata=sampled C.
  - ops 8-13: flag[1]<=flag[0], flag[0]<=F3; rf_we=0.
  - ops 14/15: if addrch, pc<=naddr; otherwise pc<=pc+1.
  - All other ops: pc<=pc+1, wrapping modulo 2^32.
  - Next state is FETCH.
- State HALT: terminal until reset; start is ignored.
- rf_we is asserted only in WB, for exactly one cycle per instruction.
- CPI = fetch wait + 1 (DECODE) + ALU_WAIT + 1 (WB). The minimum is 4 with an immediate ack and ALU_WAIT=1.
- A start pulse arriving while busy is ignored.

Optional Feature:
ALU_SEQ_PERF_EN
- Defined: adds output retired[31:0] and output stall_cycles[31:0], both reset to 0.
  - retired increments on each WB cycle.
  - stall_cycles increments on each FETCH cycle with imem_ack=0.
  - Both counters wrap at 2^32.
- Undefined: neither port nor counter exists; the rest of the behaviour is identical.

Test Plan:
- Add: reset, start, immediate ack. Fetch op=0, rd=3, ra=1, rb=2; ALU model returns C=0x0000_0007. Required: rf_we for one cycle with wa=3 and wdata=7 in cycle 4 after FETCH entry; pc=1.
- Fetch stall: hold imem_ack low for 5 cycles. Required: imem_req stays high and imem_addr stays stable; with ALU_SEQ_PERF_EN, stall_cycles=5.
- Flag shift: two op=8 instructions with F3=1 then F3=0. Required: flags=2'b10 afterwards, and alu_F1=0, alu_F2=1 during a following op=12.
- Jump: op=15 with addrch=1 and naddr=0x40. Required: pc=0x40 and the next imem_addr=0x40. Repeat with addrch=0: pc=pc+1.
- Illegal/halt: op=0x20. Required: illegal=1, halted=1, busy=0, no rf_we. A subsequent start has no effect. A separate run with op=0x7F halts with illegal=0.
- Reset mid-operation: assert reset_n=0 during EXEC. Required: outputs and state clear immediately, pc=RESET_PC, and a write issued in the cycle reset releases is suppressed.
